// File: rtl/kws_requant_seq.sv
// ============================================================================
// Module   : kws_requant_seq
// Brief    : Multi-cycle requantizer, int32 accumulator -> clamped int8
//            activation (SRDHM, RCDBPOT, offset, clamp). Optional macro
//            KWS_REQUANT_LSHIFT_EN enables the pre-SRDHM left shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kws_srdhm (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic signed [31:0] y_o
);
  logic signed [63:0] prod;
  logic signed [63:0] sum;
  logic signed [63:0] adj;

  always_comb begin
    prod = a_i * b_i;
    sum  = prod + ((prod >= 64'sd0) ? 64'sd1073741824 : -64'sd1073741823);
    // Bias negatives so the arithmetic shift truncates toward zero.
    adj  = sum[63] ? (sum + 64'sd2147483647) : sum;
    if ((a_i == 32'sh8000_0000) && (b_i == 32'sh8000_0000)) begin
      y_o = 32'sh7FFF_FFFF;
    end else begin
      y_o = 32'(adj >>> 31);
    end
  end
endmodule

module kws_rcdbpot (
  input  logic signed [31:0] x_i,
  input  logic        [4:0]  e_i,
  output logic signed [31:0] y_o
);
  logic        [31:0] mask;
  logic        [31:0] rem;
  logic        [31:0] thr;
  logic signed [31:0] sh;

  always_comb begin
    mask = (32'd1 << e_i) - 32'd1;
    rem  = x_i & mask;
    thr  = (mask >> 1) + {31'd0, x_i[31]};
    sh   = x_i >>> e_i;
    y_o  = sh + $signed({31'd0, (rem > thr)});
  end
endmodule

module kws_requant_seq #(
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [31:0]      cmd_acc,
  input  logic signed [31:0]      cmd_mult,
  input  logic signed [5:0]       cmd_shift,
  input  logic signed [31:0]      cmd_offset,
  input  logic signed [OUT_W-1:0] cmd_act_min,
  input  logic signed [OUT_W-1:0] cmd_act_max,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic signed [31:0]      rsp_data,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    SHIFT = 3'd2,
    CLAMP = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state_q;
  logic signed [31:0]      acc_q;
  logic signed [31:0]      mult_q;
  logic signed [5:0]       shift_q;
  logic signed [31:0]      offset_q;
  logic signed [OUT_W-1:0] act_min_q;
  logic signed [OUT_W-1:0] act_max_q;
  logic signed [31:0]      x_q;
  logic signed [31:0]      rsp_data_q;
  logic                    rsp_valid_q;

  logic                    accept;
  logic signed [31:0]      srdhm_a;
  logic signed [31:0]      mul_d;
  logic        [4:0]       rcd_e;
  logic signed [31:0]      shr_d;
  logic signed [32:0]      sum33;
  logic signed [32:0]      min33;
  logic signed [32:0]      max33;
  logic signed [32:0]      lo33;
  logic signed [32:0]      clamp33;
  logic signed [31:0]      clamp_d;

  assign cmd_ready = (state_q == IDLE) || ((state_q == DONE) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef KWS_REQUANT_LSHIFT_EN
  assign srdhm_a = (shift_q > 6'sd0) ? (acc_q << shift_q[4:0]) : acc_q;
`else
  assign srdhm_a = acc_q;
`endif

  // -32 cannot be negated in 5 bits; it saturates to the widest divide.
  always_comb begin
    if (shift_q == 6'sh20) begin
      rcd_e = 5'd31;
    end else if (shift_q[5]) begin
      rcd_e = 5'(-shift_q);
    end else begin
      rcd_e = 5'd0;
    end
  end

  kws_srdhm u_srdhm (
    .a_i (srdhm_a),
    .b_i (mult_q),
    .y_o (mul_d)
  );

  kws_rcdbpot u_rcdbpot (
    .x_i (x_q),
    .e_i (rcd_e),
    .y_o (shr_d)
  );

  // Lower bound first, then upper: an inverted range collapses to act_max.
  always_comb begin
    sum33   = {offset_q[31], offset_q} + {x_q[31], x_q};
    min33   = 33'(act_min_q);
    max33   = 33'(act_max_q);
    lo33    = (sum33 < min33) ? min33 : sum33;
    clamp33 = (lo33 > max33) ? max33 : lo33;
    clamp_d = 32'(clamp33);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mult_q      <= '0;
      shift_q     <= '0;
      offset_q    <= '0;
      act_min_q   <= '0;
      act_max_q   <= '0;
      x_q         <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_q     <= cmd_acc;
        mult_q    <= cmd_mult;
        shift_q   <= cmd_shift;
        offset_q  <= cmd_offset;
        act_min_q <= cmd_act_min;
        act_max_q <= cmd_act_max;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid) state_q <= MUL;
        end
        MUL: begin
          x_q     <= mul_d;
          state_q <= SHIFT;
        end
        SHIFT: begin
          x_q     <= shr_d;
          state_q <= CLAMP;
        end
        CLAMP: begin
          rsp_data_q  <= clamp_d;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= cmd_valid ? MUL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kws_requant_seq.sv
// ============================================================================
// Module   : tb_kws_requant_seq
// Brief    : Directed self-checking bench for kws_requant_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kws_requant_seq;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic signed [31:0] cmd_acc = '0;
  logic signed [31:0] cmd_mult = '0;
  logic signed [5:0]  cmd_shift = '0;
  logic signed [31:0] cmd_offset = '0;
  logic signed [7:0]  cmd_act_min = '0;
  logic signed [7:0]  cmd_act_max = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic signed [31:0] rsp_data;
  logic              busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  kws_requant_seq #(.OUT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_acc     (cmd_acc),
    .cmd_mult    (cmd_mult),
    .cmd_shift   (cmd_shift),
    .cmd_offset  (cmd_offset),
    .cmd_act_min (cmd_act_min),
    .cmd_act_max (cmd_act_max),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] acc, input logic [31:0] mult, input logic [5:0] sh,
                         input logic [31:0] off, input logic [7:0] mn, input logic [7:0] mx);
    cmd_acc     = acc;
    cmd_mult    = mult;
    cmd_shift   = sh;
    cmd_offset  = off;
    cmd_act_min = mn;
    cmd_act_max = mx;
    cmd_valid   = 1'b1;
  endtask

  task automatic accept_cmd(input string tag, input logic [31:0] acc, input logic [31:0] mult,
                            input logic [5:0] sh, input logic [31:0] off,
                            input logic [7:0] mn, input logic [7:0] mx);
    set_cmd(acc, mult, sh, off, mn, mx);
    #1;
    check_eq({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] acc, input logic [31:0] mult,
                         input logic [5:0] sh, input logic [31:0] off,
                         input logic [7:0] mn, input logic [7:0] mx, input logic [31:0] exp);
    accept_cmd(tag, acc, mult, sh, off, mn, mx);
    tick();
    check_eq({tag, "_lat1"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq({tag, "_lat2"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, "_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_ls;

    // Reset state
    tick();
    tick();
    check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_data", rsp_data, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    reset_n = 1'b1;
    tick();

    //       tag        acc           mult          shift  offset        min    max    expected
    run_vec("basic",   32'd1000,     32'h4000_0000, 6'h3F, 32'hFFFF_FF80, 8'h80, 8'h7F, 32'd122);
    run_vec("sat",     32'h8000_0000, 32'h8000_0000, 6'h00, 32'd0,        8'h80, 8'h7F, 32'd127);
    run_vec("negrnd",  32'hFFFF_FFFD, 32'h7FFF_FFFF, 6'h3F, 32'd0,        8'h80, 8'h7F, 32'hFFFF_FFFE);
    run_vec("rndup",   32'd6,        32'h4000_0000, 6'h3F, 32'd0,        8'h80, 8'h7F, 32'd2);
    run_vec("clamplo", 32'hFFFF_FC18, 32'h4000_0000, 6'h00, 32'd0,        8'h80, 8'h7F, 32'hFFFF_FF80);
    run_vec("minmax",  32'd0,        32'h4000_0000, 6'h00, 32'd0,        8'd10, 8'hF6, 32'hFFFF_FFF6);
    run_vec("shm32",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'h20, 32'd0,        8'h80, 8'h7F, 32'd1);
    run_vec("nowrap",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'h00, 32'h7FFF_FFFF, 8'h80, 8'h7F, 32'd127);
`ifdef KWS_REQUANT_LSHIFT_EN
    exp_ls = 32'd100;
`else
    exp_ls = 32'hFFFF_FFCE;
`endif
    run_vec("lshift",  32'd100,      32'h4000_0000, 6'h02, 32'hFFFF_FF9C, 8'h80, 8'h7F, exp_ls);

    // Backpressure, then a second command on the consuming edge
    accept_cmd("bp", 32'd1000, 32'h4000_0000, 6'h3F, 32'hFFFF_FF80, 8'h80, 8'h7F);
    tick();
    tick();
    tick();
    check_eq("bp_valid0", {31'd0, rsp_valid}, 32'd1);
    check_eq("bp_data0", rsp_data, 32'd122);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_hold_data", rsp_data, 32'd122);
      check_eq("bp_hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    set_cmd(32'hFFFF_FFFD, 32'h7FFF_FFFF, 6'h3F, 32'd0, 8'h80, 8'h7F);
    rsp_ready = 1'b1;
    #1;
    check_eq("b2b_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check_eq("b2b_drop", {31'd0, rsp_valid}, 32'd0);
    check_eq("b2b_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("b2b_stable", rsp_data, 32'd122);
    tick();
    check_eq("b2b_lat2", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("b2b_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("b2b_data", rsp_data, 32'hFFFF_FFFE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset while in SHIFT
    accept_cmd("mrst", 32'd1000, 32'h4000_0000, 6'h3F, 32'hFFFF_FF80, 8'h80, 8'h7F);
    tick();
    check_eq("mrst_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mrst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mrst_data", rsp_data, 32'd0);
    check_eq("mrst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("mrst_nostale", {31'd0, rsp_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/kws_requant_seq.md
Name: kws_requant_seq

Overview:
- Multi-cycle sequencer for the KWS CFU requantization path: converts one 32-bit MAC accumulator into a clamped int8 activation.
- Ordered steps: optional left shift, then SRDHM (saturating rounding doubling high multiply) with the per-channel multiplier, then RCDBPOT (rounding divide by power of two), then output-offset add and activation clamp.
- Sits between the CFU command decoder and the existing combinational srdhm/rcdbpot units, and instantiates one of each.
- Registers between steps so no combinational path spans the 32x32 multiply and the shifter.

Parameters:
- OUT_W, 8, signed width of the activation clamp bounds; result is sign-extended from this range to 32 bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_acc  in  32  signed accumulator
- cmd_mult  in  32  signed Q31 multiplier
- cmd_shift  in  6  signed shift; negative = right shift by -cmd_shift, positive = left shift
- cmd_offset  in  32  signed output zero-point
- cmd_act_min  in  OUT_W  signed lower clamp
- cmd_act_max  in  OUT_W  signed upper clamp
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result when valid&ready
- rsp_data  out  32  signed result, sign-extended
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, all internal registers 0, busy=0.
- cmd_ready = (state==IDLE) | (state==DONE & rsp_ready).
- Reset asserted mid-operation discards the operation immediately; there is no partial response.

State machine: IDLE -> MUL -> SHIFT -> CLAMP -> DONE.
- IDLE: on cmd_valid, latch all cmd_* fields and go to MUL.
- MUL: register srdhm(a, cmd_mult).
  - With KWS_REQUANT_LSHIFT_EN and shift>0: a = acc<<shift, wrapping 32-bit.
  - Otherwise: a = acc.
- SHIFT: register rcdbpot(x, e).
  - e = -shift when shift<0; e = 0 otherwise.
  - shift = -32 is treated as e = 31.
- CLAMP: y = x + offset, computed in 33 bits with no wrap; clamp to [act_min, act_max]; register into rsp_data; set rsp_valid.
  - If act_min > act_max, the result is act_max.
- DONE: hold rsp_valid and rsp_data stable until rsp_ready.
  - On handshake with cmd_valid also high: accept the new command and go to MUL.
  - On handshake without cmd_valid: go to IDLE and clear rsp_valid.

Timing:
- Latency: command accepted at edge N gives rsp_valid=1 after edge N+3.
- Peak throughput: one result per 4 cycles.
- rsp_data changes only on the CLAMP->DONE transition.

Arithmetic:
- SRDHM:
  - a=b=INT32_MIN gives INT32_MAX.
  - Otherwise (a*b + nudge)/2^31, truncated toward zero.
  - nudge = 2^30 if a*b>=0, else 1-2^30.
- RCDBPOT:
  - mask = 2^e-1, rem = x & mask, thr = (mask>>1) + (x<0).
  - Result = (x>>>e) + (rem>thr).
  - e = 0 passes x through.

Optional Feature:
- KWS_REQUANT_LSHIFT_EN defined: positive cmd_shift (1..31) left-shifts the accumulator, wrapping, before SRDHM.
- Undefined: positive cmd_shift behaves as shift 0, and the left shifter is not synthesized.
- Negative shifts behave identically either way.

Test Plan:
1. Basic path: acc=1000, mult=0x40000000, shift=-1, offset=-128, min=-128, max=127 -> rsp_data=122 exactly 3 cycles after accept.
2. Saturation: acc=mult=0x80000000, shift=0, offset=0, min=-128, max=127 -> SRDHM gives 0x7FFFFFFF, rsp_data=127.
3. Negative rounding: acc=-3, mult=0x7FFFFFFF, shift=-1, offset=0 -> rsp_data=-2 (0xFFFFFFFE).
4. Backpressure then back-to-back: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable and cmd_ready=0 throughout. Then raise rsp_ready with a second command valid -> both handshakes occur in the same cycle, and the second result arrives 3 cycles later.
5. Reset mid-operation: drop reset_n while in SHIFT -> rsp_valid, rsp_data and busy are 0 immediately. After release, cmd_ready=1 and no stale response appears.
6. Left shift: acc=100, mult=0x40000000, shift=+2, offset=-100 -> 100 with KWS_REQUANT_LSHIFT_EN, -50 without it.
